// File: rtl/muldiv_ctrl.sv
// Iterative multiply/divide unit: 32 shift-add / restoring shift-subtract steps that update the HI/LO registers.
// Optional MULDIV_EARLY_OUT_EN: a multiply finishes as soon as its remaining multiplier bits are zero.
module muldiv_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        mt_hi,
    input  logic        mt_lo,
    input  logic        mf_req,
    input  logic        flush,
    output logic        busy,
    output logic        stall_req,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int unsigned W    = 32;
    localparam int unsigned CNTW = 5;

    typedef enum logic [1:0] {IDLE, PREP, RUN, FIX} state_t;

    state_t          state;
    logic [1:0]      opReg;
    logic [W-1:0]    aReg, bReg, mr;
    logic [2*W-1:0]  acc, aux;
    logic [CNTW-1:0] cnt;
    logic            negQ, negR;

    logic           isDiv, isSigned, earlyOut, divFits;
    logic [W-1:0]   absA, absB, divRem, fixHi, fixLo;
    logic [W:0]     divTop;
    logic [2*W-1:0] mulNext, divNext, prod;

    // op[1] selects divide, op[0] selects unsigned
    always_comb begin
        isDiv    = opReg[1];
        isSigned = ~opReg[0];
        absA     = (isSigned && aReg[W-1]) ? W'(-aReg) : aReg;
        absB     = (isSigned && bReg[W-1]) ? W'(-bReg) : bReg;

        // Multiply: LSB-first, multiplicand pre-shifted so acc always holds the aligned partial product
        mulNext  = acc + (mr[0] ? aux : '0);

        // Restoring divide: acc = {remainder, quotient}, shift in quotient bits from the right
        divTop   = acc[2*W-1:W-1];
        divFits  = divTop >= {1'b0, mr};
        divRem   = W'(divTop - {1'b0, mr});
        divNext  = divFits ? {divRem, acc[W-2:0], 1'b1} : {acc[2*W-2:0], 1'b0};

        prod     = negQ ? (2*W)'(-acc) : acc;
        if (!isDiv) begin
            fixHi = prod[2*W-1:W];
            fixLo = prod[W-1:0];
        end else if (bReg == '0) begin
            fixHi = aReg;
            fixLo = '1;
        end else begin
            fixHi = negR ? W'(-acc[2*W-1:W]) : acc[2*W-1:W];
            fixLo = negQ ? W'(-acc[W-1:0]) : acc[W-1:0];
        end

`ifdef MULDIV_EARLY_OUT_EN
        earlyOut = !isDiv && (mr[W-1:1] == '0);
`else
        earlyOut = 1'b0;
`endif
    end

    assign stall_req = busy & (start | mf_req | mt_hi | mt_lo);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            opReg <= '0;
            aReg  <= '0;
            bReg  <= '0;
            mr    <= '0;
            acc   <= '0;
            aux   <= '0;
            cnt   <= '0;
            negQ  <= 1'b0;
            negR  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            opReg <= op;
                            aReg  <= src_a;
                            bReg  <= src_b;
                            state <= PREP;
                            busy  <= 1'b1;
                        end else begin
                            if (mt_hi) hi <= src_a;
                            if (mt_lo) lo <= src_a;
                        end
                    end
                    PREP: begin
                        negQ  <= isSigned & (aReg[W-1] ^ bReg[W-1]);
                        negR  <= isSigned & aReg[W-1];
                        cnt   <= CNTW'(31);
                        mr    <= absB;
                        if (isDiv) begin
                            acc <= {{W{1'b0}}, absA};
                            aux <= '0;
                        end else begin
                            acc <= '0;
                            aux <= {{W{1'b0}}, absA};
                        end
                        state <= RUN;
                    end
                    RUN: begin
                        if (isDiv) begin
                            acc <= divNext;
                        end else begin
                            acc <= mulNext;
                            aux <= aux << 1;
                            mr  <= mr >> 1;
                        end
                        cnt <= CNTW'(cnt - CNTW'(1));
                        if (cnt == '0 || earlyOut) begin
                            state <= FIX;
                            done  <= 1'b1;
                        end
                    end
                    FIX: begin
                        hi    <= fixHi;
                        lo    <= fixLo;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed testbench for muldiv_ctrl: results, latency, stall, flush, MT writes and async reset.
module tb_muldiv_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, mt_hi, mt_lo, mf_req, flush;
    logic [1:0]  op;
    logic [31:0] src_a, src_b;
    logic        busy, stall_req, done;
    logic [31:0] hi, lo;

    int nChecks = 0;
    int nFails  = 0;
    int lat;
    logic doneSeen;

    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

    muldiv_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .mt_hi(mt_hi), .mt_lo(mt_lo), .mf_req(mf_req), .flush(flush),
        .busy(busy), .stall_req(stall_req), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Drive start for cycle N; returns during cycle N+1
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op = o; src_a = a; src_b = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Returns done cycle offset from N; leaves the bench in cycle N+lat+1
    task automatic waitDone(output int l);
        int c;
        c = 1;
        l = -1;
        while (c < 60) begin
            @(negedge clk);
            if (done) begin
                l = c;
                break;
            end
            @(posedge clk); #1;
            c++;
        end
        if (l < 0) check("done_timeout", 64'd1, 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic runOp(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int expLat,
                         input logic [31:0] expHi, input logic [31:0] expLo);
        int l;
        issue(o, a, b);
        waitDone(l);
        check({tag, "_lat"}, 64'(l), 64'(expLat));
        check({tag, "_hi"}, 64'(hi), 64'(expHi));
        check({tag, "_lo"}, 64'(lo), 64'(expLo));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; op = '0; src_a = '0; src_b = '0;
        mt_hi = 1'b0; mt_lo = 1'b0; mf_req = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_stall", 64'(stall_req), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        runOp("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 32'hFFFF_FFFE, 32'h0000_0001);
        runOp("div_m7_2", DIV, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        runOp("divu_7_0", DIVU, 32'd7, 32'd0, 34, 32'd7, 32'hFFFF_FFFF);
        runOp("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'd0, 32'h8000_0000);
        runOp("div_m9_0", DIV, 32'hFFFF_FFF7, 32'd0, 34, 32'hFFFF_FFF7, 32'hFFFF_FFFF);
        runOp("mult_m5_m6", MULT, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 34, 32'd0, 32'd30);
`ifdef MULDIV_EARLY_OUT_EN
        runOp("multu_5_3", MULTU, 32'd5, 32'd3, 4, 32'd0, 32'd15);
`else
        runOp("multu_5_3", MULTU, 32'd5, 32'd3, 34, 32'd0, 32'd15);
`endif

        // MTHI/MTLO in IDLE, both at once
        src_a = 32'h1234_5678; mt_hi = 1'b1; mt_lo = 1'b1;
        @(posedge clk); #1;
        mt_hi = 1'b0; mt_lo = 1'b0;
        check("mt_hi", 64'(hi), 64'h1234_5678);
        check("mt_lo", 64'(lo), 64'h1234_5678);
        src_a = 32'hAAAA_0000; mt_lo = 1'b1;
        @(posedge clk); #1;
        mt_lo = 1'b0;
        check("mtlo_only_hi", 64'(hi), 64'h1234_5678);
        check("mtlo_only_lo", 64'(lo), 64'hAAAA_0000);

        // Flush at N+10 abandons the divide, HI/LO untouched
        issue(DIVU, 32'd100, 32'd7);
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        doneSeen = 1'b0;
        repeat (40) begin @(negedge clk); if (done) doneSeen = 1'b1; end
        check("flush_done", 64'(doneSeen), 64'd0);
        check("flush_hi", 64'(hi), 64'h1234_5678);
        check("flush_lo", 64'(lo), 64'hAAAA_0000);

        // Flush with start in IDLE does not start
        @(posedge clk); #1;
        op = MULTU; src_a = 32'd2; src_b = 32'd2; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        check("flush_start_busy", 64'(busy), 64'd0);

        // Start while busy is ignored and stalls
        issue(DIVU, 32'd100, 32'd7);
        repeat (2) begin @(posedge clk); #1; end
        op = MULTU; src_a = 32'd9; src_b = 32'd9; start = 1'b1;
        @(negedge clk);
        check("busy_start_stall", 64'(stall_req), 64'd1);
        @(posedge clk); #1;
        start = 1'b0;
        waitDone(lat);
        check("busy_start_lat", 64'(lat + 0), 64'd31);
        check("divu_100_7_hi", 64'(hi), 64'd2);
        check("divu_100_7_lo", 64'(lo), 64'd14);

        // mf_req from N+5: stall through N+34, released at N+35
        issue(MULTU, 32'd1000, 32'd1000);
        repeat (4) begin @(posedge clk); #1; end
        mf_req = 1'b1;
        @(negedge clk);
        check("mf_stall_n5", 64'(stall_req), 64'd1);
        repeat (29) begin @(posedge clk); #1; end
        @(negedge clk);
        check("mf_stall_n34", 64'(stall_req), 64'd1);
        check("mf_done_n34", 64'(done), 64'd1);
        @(posedge clk); #1;
        check("mf_stall_n35", 64'(stall_req), 64'd0);
        check("mf_lo", 64'(lo), 64'd1_000_000);
        check("mf_hi", 64'(hi), 64'd0);
        mf_req = 1'b0;

        // Async reset mid-operation at N+20
        issue(MULTU, 32'd7, 32'd7);
        repeat (19) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_hi", 64'(hi), 64'd0);
        check("arst_lo", 64'(lo), 64'd0);
        check("arst_stall", 64'(stall_req), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        runOp("mult_3_m4", MULT, 32'd3, 32'hFFFF_FFFC, 34, 32'hFFFF_FFFF, 32'hFFFF_FFF4);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 The block SHALL have these ports, one clock, asynchronous active-low reset:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  EX-stage multiply/divide issue, one cycle
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- src_a  in  32  forwarded operand A (ALU_A path)
- src_b  in  32  forwarded operand B (ALU_B path)
- mt_hi  in  1  MTHI write request
- mt_lo  in  1  MTLO write request
- mf_req  in  1  MFHI/MFLO read in EX
- flush  in  1  pipeline flush, abort operation
- busy  out  1  operation in progress
- stall_req  out  1  freeze IF/ID/EX this cycle
- done  out  1  one-cycle completion pulse
- hi  out  32  HI register
- lo  out  32  LO register

Function
REQ-002 FSM states SHALL be IDLE, PREP, RUN, FIX; busy = (state != IDLE).
REQ-003 IDLE: start=1, flush=0 SHALL latch op/src_a/src_b and go to PREP next edge.
REQ-004 PREP (1 cycle): signed ops SHALL take absolute values and record result sign(s); unsigned ops pass through; iteration counter SHALL load 31.
REQ-005 RUN: one iteration per cycle: multiply = shift-add on 64-bit accumulator; divide = restoring shift-subtract on 64-bit remainder/quotient; counter decrements; at counter 0, next state FIX.
REQ-006 FIX (1 cycle): apply sign correction (product negated if signs differ; quotient negated if signs differ; remainder takes dividend sign); write HI/LO at end of cycle; done=1 in FIX only; next state IDLE.
REQ-007 Multiply: {hi,lo} = 64-bit product. Divide: lo = quotient, hi = remainder.
REQ-008 Divide by zero: SHALL yield lo=32'hFFFF_FFFF, hi=dividend (original src_a), same latency.
REQ-009 DIV 32'h8000_0000 / 32'hFFFF_FFFF SHALL yield lo=32'h8000_0000, hi=0.
REQ-010 Latency (no early-out): start cycle N -> done in cycle N+34; HI/LO valid from N+35.
REQ-011 stall_req SHALL equal busy & (start | mf_req | mt_hi | mt_lo); purely combinational from current state.
REQ-012 start while busy SHALL be ignored (stalled; reissued by held pipeline after IDLE).
REQ-013 mt_hi/mt_lo in IDLE SHALL write src_a to hi/lo next edge; both asserted writes both; concurrent start takes priority over mt_*.
REQ-014 flush SHALL force IDLE next edge from any state, HI/LO unchanged, done not asserted; flush with start in IDLE SHALL not start.
REQ-015 hi/lo SHALL change only at FIX or mt_* writes.

Reset
REQ-016 rst_n=0 SHALL immediately set state IDLE, hi=0, lo=0, counter=0, busy=0, done=0, stall_req=0, regardless of clk.
REQ-017 Reset mid-operation SHALL discard the operation; first start after rst_n release behaves per REQ-003.

Configuration
REQ-018 Macro MULDIV_EARLY_OUT_EN defined: for MULT/MULTU in RUN, when remaining unprocessed multiplier bits are all zero, the FSM SHALL jump to FIX next edge (accumulator pre-aligned); divide unaffected; result identical. Undefined: fixed 32 RUN cycles always.

Verification
REQ-019 MULTU 32'hFFFF_FFFF x 32'hFFFF_FFFF -> hi=32'hFFFF_FFFE, lo=32'h0000_0001, done at N+34 (macro off).
REQ-020 DIV -7 / 2 -> lo=32'hFFFF_FFFD (-3), hi=32'hFFFF_FFFF (-1); DIVU 7/0 -> lo=32'hFFFF_FFFF, hi=7.
REQ-021 mf_req asserted at N+5 during RUN -> stall_req=1 through N+34, 0 at N+35; read returns new hi/lo.
REQ-022 flush at N+10 -> busy=0 at N+11, done never pulses, hi/lo keep prior values (e.g. set by MTHI 32'h1234_5678).
REQ-023 rst_n low at N+20 (asynchronous, mid-cycle) -> busy, hi, lo = 0 immediately; subsequent MULT 3 x -4 -> hi=32'hFFFF_FFFF, lo=32'hFFFF_FFF4.
REQ-024 With MULDIV_EARLY_OUT_EN: MULTU 5 x 3 -> done before N+34, hi=0, lo=15; same test without macro -> done at N+34.
